// File: rtl/sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder_if
// Description : Backdoor preload/inspection port of the SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_responder_if;
    logic        bd_en;
    logic        bd_we;
    logic [17:0] bd_addr;
    logic [15:0] bd_wdata;
    logic [15:0] bd_rdata;
    logic        bd_ack;

    modport master (
        output bd_en, bd_we, bd_addr, bd_wdata,
        input  bd_rdata, bd_ack
    );

    modport slave (
        input  bd_en, bd_we, bd_addr, bd_wdata,
        output bd_rdata, bd_ack
    );
endinterface
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder
// Description : Behavioural stand-in for a 16-bit async SRAM chip, with
//               backdoor port, access counters and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_responder #(
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [17:0] SRAMaddress,
    input  wire logic        SRAMWEn,
    input  wire logic        SRAMOE,
    inout  wire       [15:0] SRAMdata,
    sram_responder_if.slave  bd,
    input  wire logic        clr_stats,
    output logic      [15:0] rd_count,
    output logic      [15:0] wr_count,
    output logic             collision_err,
    output logic             oob_err
);
    localparam int          c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [17:0] c_DEPTH = 18'(DEPTH);

    logic [15:0]         r_mem [DEPTH];
    logic [READ_LAT-1:0] r_pv;
    logic [17:0]         r_pa [READ_LAT];
    logic [15:0]         r_bd_rdata;
    logic                r_bd_ack;
    logic [15:0]         r_rd_count;
    logic [15:0]         r_wr_count;
    logic                r_collision;
    logic                r_oob;

    logic                w_pin_wr;
    logic                w_rd_req;
    logic                w_pin_oob;
    logic                w_bd_acc;
    logic                w_bd_oob;
    logic                w_last_valid;
    logic [17:0]         w_last_addr;
    logic [15:0]         w_rdata;
    logic                w_bus_drive;
    logic                w_mem_we;
    logic [c_AW-1:0]     w_mem_idx;
    logic [15:0]         w_mem_wd;

    assign w_pin_wr  = !SRAMWEn;
    assign w_rd_req  = !SRAMOE && SRAMWEn;
    assign w_pin_oob = (SRAMaddress >= c_DEPTH);
    // A pin write in the same cycle drops the backdoor request entirely.
    assign w_bd_acc  = bd.bd_en && SRAMWEn;
    assign w_bd_oob  = (bd.bd_addr >= c_DEPTH);

    assign w_last_valid = r_pv[READ_LAT-1];
    assign w_last_addr  = r_pa[READ_LAT-1];
    assign w_rdata      = (w_last_addr < c_DEPTH) ? r_mem[w_last_addr[c_AW-1:0]] : 16'h0000;
    assign w_bus_drive  = w_last_valid && SRAMWEn;
    assign SRAMdata     = w_bus_drive ? w_rdata : 16'hzzzz;

    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = '0;
        w_mem_wd  = '0;
        if (w_pin_wr) begin
            w_mem_we  = !w_pin_oob;
            w_mem_idx = SRAMaddress[c_AW-1:0];
            w_mem_wd  = SRAMdata;
        end else if (w_bd_acc && bd.bd_we) begin
            w_mem_we  = !w_bd_oob;
            w_mem_idx = bd.bd_addr[c_AW-1:0];
            w_mem_wd  = bd.bd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_pa[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_req;
            r_pa[0] <= SRAMaddress;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bd_rdata <= '0;
            r_bd_ack   <= 1'b0;
        end else begin
            r_bd_ack <= w_bd_acc;
            if (w_bd_acc && !bd.bd_we) begin
                r_bd_rdata <= w_bd_oob ? 16'h0000 : r_mem[bd.bd_addr[c_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
        end else if (clr_stats) begin
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            if (w_rd_req && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_pin_wr && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            // Write strobe overlapping either a new read request or a due read slot.
            if (w_pin_wr && (!SRAMOE || w_last_valid)) begin
                r_collision <= 1'b1;
            end
            if ((w_pin_wr || w_rd_req) && w_pin_oob) begin
                r_oob <= 1'b1;
            end
        end
    end

    assign bd.bd_rdata   = r_bd_rdata;
    assign bd.bd_ack     = r_bd_ack;
    assign rd_count      = r_rd_count;
    assign wr_count      = r_wr_count;
    assign collision_err = r_collision;
    assign oob_err       = r_oob;
endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_responder
// Description : Directed self-checking bench for sram_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_responder;
    logic        clk;
    logic        rst;
    logic [17:0] sram_addr;
    logic        sram_wen;
    logic        sram_oe;
    logic [15:0] tb_wdata;
    wire  [15:0] sram_data;
    logic        clr_stats;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        collision_err;
    logic        oob_err;

    int n_checks = 0;
    int n_fails  = 0;

    sram_responder_if bd_if ();

    assign sram_data = sram_wen ? 16'hzzzz : tb_wdata;

    sram_responder #(.DEPTH(4096), .READ_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .SRAMaddress   (sram_addr),
        .SRAMWEn       (sram_wen),
        .SRAMOE        (sram_oe),
        .SRAMdata      (sram_data),
        .bd            (bd_if.slave),
        .clr_stats     (clr_stats),
        .rd_count      (rd_count),
        .wr_count      (wr_count),
        .collision_err (collision_err),
        .oob_err       (oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic bd_go(input logic we, input logic [17:0] addr, input logic [15:0] wdata);
        bd_if.bd_en    = 1'b1;
        bd_if.bd_we    = we;
        bd_if.bd_addr  = addr;
        bd_if.bd_wdata = wdata;
        tick();
        bd_if.bd_en    = 1'b0;
    endtask

    task automatic pulse_clr;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sram_addr = '0; sram_wen = 1'b1; sram_oe = 1'b1; tb_wdata = '0;
        clr_stats = 1'b0;
        bd_if.bd_en = 1'b0; bd_if.bd_we = 1'b0; bd_if.bd_addr = '0; bd_if.bd_wdata = '0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Idle after reset
        settle();
        check_eq("idle_drive",  32'(dut.w_bus_drive), 32'd0);
        check_eq("idle_rd_cnt", 32'(rd_count), 32'd0);
        check_eq("idle_wr_cnt", 32'(wr_count), 32'd0);
        check_eq("idle_coll",   32'(collision_err), 32'd0);
        check_eq("idle_oob",    32'(oob_err), 32'd0);
        check_eq("idle_ack",    32'(bd_if.bd_ack), 32'd0);
        check_eq("idle_bdrd",   32'(bd_if.bd_rdata), 32'd0);

        // Pin writes then streamed reads
        tick();
        sram_addr = 18'd4; sram_wen = 1'b0; tb_wdata = 16'hBEEF;
        tick();
        sram_addr = 18'd5; tb_wdata = 16'hCAFE;
        tick();
        sram_wen = 1'b1; sram_oe = 1'b0; sram_addr = 18'd4;
        tick();
        sram_addr = 18'd5;
        settle();
        check_eq("rd4_drive", 32'(dut.w_bus_drive), 32'd1);
        check_eq("rd4_data",  32'(sram_data), 32'h0000BEEF);
        tick();
        sram_oe = 1'b1;
        settle();
        check_eq("rd5_drive", 32'(dut.w_bus_drive), 32'd1);
        check_eq("rd5_data",  32'(sram_data), 32'h0000CAFE);
        tick();
        settle();
        check_eq("rd_done_drive", 32'(dut.w_bus_drive), 32'd0);
        check_eq("rw_rd_cnt", 32'(rd_count), 32'd2);
        check_eq("rw_wr_cnt", 32'(wr_count), 32'd2);

        // Backdoor write, pin read back
        tick();
        bd_go(1'b1, 18'd7, 16'h1234);
        settle();
        check_eq("bdw_ack", 32'(bd_if.bd_ack), 32'd1);
        tick();
        sram_oe = 1'b0; sram_addr = 18'd7;
        tick();
        sram_oe = 1'b1;
        settle();
        check_eq("bdw_pin_rd", 32'(sram_data), 32'h00001234);

        // Pin write, backdoor read back
        tick();
        sram_wen = 1'b0; sram_addr = 18'd7; tb_wdata = 16'h5555;
        tick();
        sram_wen = 1'b1;
        bd_go(1'b0, 18'd7, 16'h0000);
        settle();
        check_eq("bdr_ack",   32'(bd_if.bd_ack), 32'd1);
        check_eq("bdr_rdata", 32'(bd_if.bd_rdata), 32'h00005555);
        tick();
        settle();
        check_eq("bdr_ack_pulse", 32'(bd_if.bd_ack), 32'd0);

        // Backdoor dropped by a simultaneous pin write
        tick();
        sram_wen = 1'b0; sram_addr = 18'd9; tb_wdata = 16'h0101;
        bd_go(1'b0, 18'd4, 16'h0000);
        sram_wen = 1'b1;
        settle();
        check_eq("drop_ack",   32'(bd_if.bd_ack), 32'd0);
        check_eq("drop_rdata", 32'(bd_if.bd_rdata), 32'h00005555);

        // WEn and OE low together
        tick();
        sram_wen = 1'b0; sram_oe = 1'b0; sram_addr = 18'd3; tb_wdata = 16'hA5A5;
        tick();
        sram_wen = 1'b1; sram_oe = 1'b1;
        settle();
        check_eq("coll_flag",  32'(collision_err), 32'd1);
        check_eq("coll_drive", 32'(dut.w_bus_drive), 32'd0);
        check_eq("coll_rd_cnt", 32'(rd_count), 32'd3);
        check_eq("coll_wr_cnt", 32'(wr_count), 32'd5);
        tick();
        settle();
        check_eq("coll_drive2", 32'(dut.w_bus_drive), 32'd0);
        tick();
        bd_go(1'b0, 18'd3, 16'h0000);
        settle();
        check_eq("coll_mem3", 32'(bd_if.bd_rdata), 32'h0000A5A5);
        tick();
        pulse_clr();
        settle();
        check_eq("clr_coll",   32'(collision_err), 32'd0);
        check_eq("clr_rd_cnt", 32'(rd_count), 32'd0);
        check_eq("clr_wr_cnt", 32'(wr_count), 32'd0);

        // Write strobe landing on a due read slot
        tick();
        sram_oe = 1'b0; sram_addr = 18'd4;
        tick();
        sram_oe = 1'b1; sram_wen = 1'b0; sram_addr = 18'd10; tb_wdata = 16'h0202;
        settle();
        check_eq("due_coll_drive", 32'(dut.w_bus_drive), 32'd0);
        tick();
        sram_wen = 1'b1;
        settle();
        check_eq("due_coll_flag", 32'(collision_err), 32'd1);
        tick();
        pulse_clr();

        // Out-of-range pin accesses
        bd_go(1'b1, 18'd0, 16'h0F0F);
        sram_oe = 1'b0; sram_addr = 18'd4096;
        tick();
        sram_oe = 1'b1;
        settle();
        check_eq("oob_rd_drive", 32'(dut.w_bus_drive), 32'd1);
        check_eq("oob_rd_data",  32'(sram_data), 32'h00000000);
        check_eq("oob_flag",     32'(oob_err), 32'd1);
        check_eq("oob_rd_cnt",   32'(rd_count), 32'd1);
        tick();
        sram_wen = 1'b0; sram_addr = 18'd4096; tb_wdata = 16'hDEAD;
        tick();
        sram_wen = 1'b1;
        settle();
        check_eq("oob_wr_cnt", 32'(wr_count), 32'd1);
        tick();
        bd_go(1'b0, 18'd0, 16'h0000);
        settle();
        check_eq("oob_mem0", 32'(bd_if.bd_rdata), 32'h00000F0F);

        // Out-of-range backdoor accesses
        tick();
        pulse_clr();
        bd_go(1'b1, 18'd4096, 16'h7777);
        bd_go(1'b0, 18'd4096, 16'h0000);
        settle();
        check_eq("bd_oob_rdata", 32'(bd_if.bd_rdata), 32'h00000000);
        check_eq("bd_oob_ack",   32'(bd_if.bd_ack), 32'd1);
        check_eq("bd_oob_flag",  32'(oob_err), 32'd0);
        tick();
        bd_go(1'b0, 18'd0, 16'h0000);
        settle();
        check_eq("bd_oob_mem0", 32'(bd_if.bd_rdata), 32'h00000F0F);

        // Reset while a read is on the bus
        tick();
        sram_oe = 1'b0; sram_addr = 18'd4;
        tick();
        sram_oe = 1'b1;
        #1;
        check_eq("midrst_pre_drive", 32'(dut.w_bus_drive), 32'd1);
        check_eq("midrst_pre_data",  32'(sram_data), 32'h0000BEEF);
        rst = 1'b0;
        #1;
        check_eq("midrst_drive",  32'(dut.w_bus_drive), 32'd0);
        check_eq("midrst_rd_cnt", 32'(rd_count), 32'd0);
        check_eq("midrst_bdrd",   32'(bd_if.bd_rdata), 32'd0);
        tick();
        rst = 1'b1;

        // Counter saturation
        tick();
        sram_wen = 1'b0; sram_addr = 18'd20; tb_wdata = 16'h0000;
        repeat (70000) tick();
        sram_wen = 1'b1;
        settle();
        check_eq("sat_wr_cnt", 32'(wr_count), 32'h0000FFFF);
        check_eq("sat_rd_cnt", 32'(rd_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
